// File: rtl/anim_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | anim_sequencer_if : button/autoplay inputs and animation outputs      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface anim_sequencer_if;
  logic [3:0] i_btn;
  logic       i_auto_en;
  logic [4:0] i_step_max;
  logic [3:0] o_anim;
  logic [4:0] o_step;
  logic       o_tick;
  logic [4:0] o_level;
  logic       o_anim_change;

  modport master (
    output i_btn, i_auto_en, i_step_max,
    input  o_anim, o_step, o_tick, o_level, o_anim_change
  );

  modport slave (
    input  i_btn, i_auto_en, i_step_max,
    output o_anim, o_step, o_tick, o_level, o_anim_change
  );
endinterface
`default_nettype wire

// File: rtl/anim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | anim_sequencer : button debounce/arbitration, animation, frame timing |
// | Optional autoplay built when ANIM_AUTOPLAY_EN is defined.   Rev 1.0   |
// +----------------------------------------------------------------------+
module anim_sequencer #(
  parameter int NUM_ANIM        = 16,
  parameter int DEBOUNCE_CYCLES = 512,
  parameter int STEP_CYCLES     = 1_000_000,
  parameter int MAX_LEVEL       = 19,
  parameter int DEFAULT_LEVEL   = 10,
  parameter int DWELL_LOOPS     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  anim_sequencer_if.slave  bus
);

  localparam logic [11:0] c_DB_MAX  = 12'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  c_LAST    = 4'(NUM_ANIM - 1);
  localparam logic [4:0]  c_MAX_LVL = 5'(MAX_LEVEL);
  localparam logic [4:0]  c_DEF_LVL = 5'(DEFAULT_LEVEL);
  localparam logic [24:0] c_STEP    = 25'(STEP_CYCLES);
  localparam logic [24:0] c_DEF_PER = 25'(DEFAULT_LEVEL * STEP_CYCLES);

  logic [3:0]  w_rise;
  logic [3:0]  r_pend;
  logic [3:0]  w_grant;
  logic [3:0]  r_anim,   w_anim_nxt;
  logic [4:0]  r_step,   w_step_nxt;
  logic [4:0]  r_level,  w_level_nxt;
  logic [24:0] r_period, w_period_nxt;
  logic [24:0] r_timer,  w_timer_nxt;
  logic        r_tick;
  logic        r_chg_d;
  logic        r_anim_change;
  logic        w_term;
  logic        w_wrap;
  logic        w_auto_adv;
  logic        w_anim_chg;

  // r_armed blocks a press that was already held through reset
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [11:0] r_cnt;
    logic        r_db_q;
    logic        r_armed;
    logic        w_db;

    assign w_db       = (r_cnt == c_DB_MAX);
    assign w_rise[gi] = w_db & ~r_db_q & r_armed;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_db_q  <= 1'b0;
        r_armed <= 1'b0;
      end else begin
        r_db_q <= w_db;
        if (!bus.i_btn[gi]) begin
          r_cnt   <= '0;
          r_armed <= 1'b1;
        end else if (r_cnt != c_DB_MAX) begin
          r_cnt <= r_cnt + 12'd1;
        end
      end
    end
  end

  always_comb begin
    w_grant = 4'b0000;
    if (r_pend[0])      w_grant = 4'b0001;
    else if (r_pend[1]) w_grant = 4'b0010;
    else if (r_pend[2]) w_grant = 4'b0100;
    else if (r_pend[3]) w_grant = 4'b1000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_grant) | w_rise;
  end

  assign w_term = (r_timer == r_period - 25'd1);
  assign w_wrap = w_term & ~(|w_grant) & (r_step >= bus.i_step_max);

`ifdef ANIM_AUTOPLAY_EN
  localparam logic [7:0] c_DWELL_M1 = 8'(DWELL_LOOPS - 1);
  logic [7:0] r_loops;

  assign w_auto_adv = bus.i_auto_en & w_wrap & (r_loops == c_DWELL_M1);

  always_ff @(posedge clk) begin
    if (!rst_n)                           r_loops <= '0;
    else if (!bus.i_auto_en || w_anim_chg) r_loops <= '0;
    else if (w_wrap)                      r_loops <= r_loops + 8'd1;
  end
`else
  assign w_auto_adv = 1'b0;
`endif

  // Button events pre-empt the frame advance and restart the timer
  always_comb begin
    w_anim_nxt   = r_anim;
    w_step_nxt   = r_step;
    w_level_nxt  = r_level;
    w_period_nxt = r_period;
    w_timer_nxt  = w_term ? 25'd0 : r_timer + 25'd1;
    w_anim_chg   = 1'b0;
    if (w_grant[0]) begin
      w_anim_nxt  = (r_anim == c_LAST) ? 4'd0 : r_anim + 4'd1;
      w_step_nxt  = '0;
      w_timer_nxt = '0;
      w_anim_chg  = 1'b1;
    end else if (w_grant[1]) begin
      w_anim_nxt  = (r_anim == 4'd0) ? c_LAST : r_anim - 4'd1;
      w_step_nxt  = '0;
      w_timer_nxt = '0;
      w_anim_chg  = 1'b1;
    end else if (w_grant[2]) begin
      w_timer_nxt = '0;
      if (r_level != c_MAX_LVL) begin
        w_level_nxt  = r_level + 5'd1;
        w_period_nxt = r_period + c_STEP;
      end
    end else if (w_grant[3]) begin
      w_timer_nxt = '0;
      if (r_level != 5'd1) begin
        w_level_nxt  = r_level - 5'd1;
        w_period_nxt = r_period - c_STEP;
      end
    end else if (w_term) begin
      w_step_nxt = (r_step >= bus.i_step_max) ? 5'd0 : r_step + 5'd1;
      if (w_auto_adv) begin
        w_anim_nxt = (r_anim == c_LAST) ? 4'd0 : r_anim + 4'd1;
        w_anim_chg = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anim        <= '0;
      r_step        <= '0;
      r_level       <= c_DEF_LVL;
      r_period      <= c_DEF_PER;
      r_timer       <= '0;
      r_tick        <= 1'b0;
      r_chg_d       <= 1'b0;
      r_anim_change <= 1'b0;
    end else begin
      r_anim        <= w_anim_nxt;
      r_step        <= w_step_nxt;
      r_level       <= w_level_nxt;
      r_period      <= w_period_nxt;
      r_timer       <= w_timer_nxt;
      r_tick        <= (w_timer_nxt == w_period_nxt - 25'd1);
      r_chg_d       <= w_anim_chg;
      r_anim_change <= r_chg_d;
    end
  end

  assign bus.o_anim        = r_anim;
  assign bus.o_step        = r_step;
  assign bus.o_tick        = r_tick;
  assign bus.o_level       = r_level;
  assign bus.o_anim_change = r_anim_change;

endmodule
`default_nettype wire

// File: doc/anim_sequencer.md
# anim_sequencer

Control block for the seven-segment animation datapath: debounces the four user buttons, arbitrates their events one per cycle, and sequences which animation plays, its frame index and its frame rate. It drives the `seg7` decoder's `animation` and `counter` inputs and takes the per-animation frame limit from the `changing` table. An optional autoplay mode cycles through animations without user input.

## Interface
- `NUM_ANIM`, 16: number of animations, 2..16; index range 0..NUM_ANIM-1.
- `DEBOUNCE_CYCLES`, 512: consecutive high samples required before a button counts as pressed; 2..4095.
- `STEP_CYCLES`, 1_000_000: frame-period increment per speed level, in clocks.
- `MAX_LEVEL`, 19: slowest speed level; must satisfy MAX_LEVEL*STEP_CYCLES ≤ 2^25-1.
- `DEFAULT_LEVEL`, 10: speed level after reset; 1..MAX_LEVEL.
- `DWELL_LOOPS`, 4: completed frame loops per animation in autoplay; 1..255.
- `clk` in 1: system clock (10 MHz nominal).
- `rst_n` in 1: reset, synchronous, active-low.
- `btn` in 4: raw buttons; [0] next anim, [1] prev anim, [2] slower, [3] faster.
- `auto_en` in 1: autoplay request; ignored unless ANIM_AUTOPLAY_EN is defined.
- `step_max` in 5: last frame index of the current animation, inclusive, from `changing`.
- `anim` out 4: current animation index.
- `step` out 5: current frame index.
- `tick` out 1: one-cycle pulse on each frame advance.
- `level` out 5: current speed level.
- `anim_change` out 1: one-cycle pulse in the cycle after `anim` changes.

## Operation
- Debounce, per button:
  - 12-bit counter increments while raw is high and saturates at DEBOUNCE_CYCLES.
  - Counter clears when raw is low.
  - Debounced level is high while count == DEBOUNCE_CYCLES.
  - A 0→1 transition of the debounced level sets that button's pending flag. A held button yields exactly one event.
- Arbiter: each cycle it services at most one pending flag and clears only that flag. Fixed priority: next > prev > slower > faster. Lower-priority flags stay pending and are serviced on later cycles.
- Next: `anim` increments; NUM_ANIM-1 wraps to 0. Prev: `anim` decrements; 0 wraps to NUM_ANIM-1.
  - Both clear `step`, the frame timer and the loop counter, and pulse `anim_change`.
- Slower: `level`+1, saturating at MAX_LEVEL. Faster: `level`-1, saturating at 1.
  - The frame period register moves by ±STEP_CYCLES in the same edge and always equals level*STEP_CYCLES. No multiplier is used.
  - The frame timer clears. A saturated request still clears the timer.
  - `step` is unchanged.
- Frame timer: 25-bit counter runs 0..period-1.
  - `tick` is high in the cycle the count equals period-1.
  - On that edge the counter returns to 0, and `step` increments, or returns to 0 if `step` ≥ `step_max`.
  - If `step_max` decreases below the current `step`, the next tick wraps `step` to 0.
- Simultaneous events: a serviced animation or speed event in the same cycle as a timer terminal count takes precedence. No `step` advance occurs and the timer clears.

## Timing
- Reset (`rst_n` low at a clk edge): `anim`=0, `step`=0, `tick`=0, `level`=DEFAULT_LEVEL, `anim_change`=0, period=DEFAULT_LEVEL*STEP_CYCLES. Debounce counters, pending flags, timer and loop counter are all 0. Reset mid-press discards the press; the button must be released and re-pressed.
- Button latency, from the first high sample:
  - Debounced level high after DEBOUNCE_CYCLES edges.
  - Pending flag set 1 cycle later.
  - Serviced the following cycle, when `anim`/`level` update.
  - `anim_change` high one cycle after that.
- With no contention, the press-to-`anim` latency is DEBOUNCE_CYCLES+2 cycles.
- Each queued lower-priority event adds one cycle.
- Frame period: exactly level*STEP_CYCLES clocks between `tick` pulses when no events occur.
- All outputs are registered.

## Configuration
- `ANIM_AUTOPLAY_EN` defined:
  - While `auto_en` is high, an 8-bit loop counter counts `step` wraps (step_max→0).
  - When it reaches DWELL_LOOPS, `anim` advances exactly as a Next event, on the same edge as that wrap.
  - The counter clears on any animation change and whenever `auto_en` is low.
  - If a button event is serviced on the same edge, the button wins and the auto advance is dropped.
- Undefined: no loop counter is built. `auto_en` has no effect; `anim` changes only via buttons.

## Test plan
Bench parameters: STEP_CYCLES=4, DEBOUNCE_CYCLES=8, DEFAULT_LEVEL=2, MAX_LEVEL=5, NUM_ANIM=16, DWELL_LOOPS=2.
- Reset, `step_max`=3, idle → `tick` every 8 cycles; `step` goes 0,1,2,3,0; `anim`=0, `level`=2.
- Bounce on btn[0]: 7 highs, 1 low, then a 20-cycle hold → no change during the bounce; `anim`=1 exactly 10 cycles after the hold begins; one `anim_change` pulse; no second event while held.
- btn[1] press from `anim`=0 → `anim`=15 with `step`=0. btn[3] pressed ×3 from level 2 → level 1, saturating. btn[2] pressed ×5 → level 5, tick period 20.
- btn[0] and btn[3] debounce on the same cycle → `anim` updates first and `level` decrements one cycle later; both are serviced.
- With ANIM_AUTOPLAY_EN, `auto_en`=1, `step_max`=1 → `anim` increments every 2 loops = 4 ticks. Drop `auto_en` mid-dwell → no advance; the loop count restarts from 0.
- Assert `rst_n` low during a timer run at level 4 → all outputs at reset values on the next edge; ticks resume with period 8.
